meta_req_arbiter: RTL and testbench
===================================

# meta_req_arbiter

- Round-robin arbiter that shares one metadata decoder request/response port among NUM_REQ BSR scheduler lanes.
- Picks one requester per cycle, forwards its address to the decoder and records the winner's ID in an in-order tag FIFO.
- Routes each decoder response back to the requester at the FIFO head.
- Sits between the scheduler lanes and the metadata decoder; the decoder is unchanged and returns responses in request order.

## Interface
- NUM_REQ, 4, number of requester lanes (2..8)
- DATA_WIDTH, 32, metadata word width
- ADDR_WIDTH, 32, metadata address width
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; also the tag FIFO depth (power of two, ≥2)
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-lane request valid; held until accepted
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-lane addresses; lane i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_rdata  out  DATA_WIDTH  shared response data
- rsp_ready  in  NUM_REQ  per-lane response accept
- dec_req_valid  out  1  request to decoder
- dec_req_addr  out  ADDR_WIDTH  address to decoder
- dec_req_ready  in  1  decoder accepts request
- dec_meta_valid  in  1  decoder response valid
- dec_meta_rdata  in  DATA_WIDTH  decoder response data
- dec_meta_ready  out  1  arbiter accepts response
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag-FIFO occupancy
- err_orphan  out  1  sticky flag: decoder response arrived with no outstanding request

## Operation
**Eligibility**
- A lane is eligible when req_valid[i]=1 and occupancy < MAX_OUTSTANDING (registered value).

**Arbitration**
- When no grant is locked, the winner is the first eligible lane at or after rr_ptr, scanning upward modulo NUM_REQ.
- dec_req_valid = a winner exists. dec_req_addr = the winner's address.
- req_ready[winner] = dec_req_ready.

**Grant lock**
- If dec_req_valid=1 and dec_req_ready=0, lock_vld<=1 and lock_id<=winner.
- While locked, the winner is forced to lock_id, even if a higher-priority lane asserts valid. This keeps valid and address stable until the handshake.
- Lock clears on the handshake.

**Handshake (dec_req_valid & dec_req_ready)**
- Push the winner ID into the tag FIFO.
- rr_ptr <= (winner+1) mod NUM_REQ.

**Response routing**
- head = FIFO head ID.
- When FIFO is non-empty: rsp_valid[head] = dec_meta_valid; rsp_rdata = dec_meta_rdata; dec_meta_ready = rsp_ready[head].
- When FIFO is empty: dec_meta_ready=0 and all rsp_valid=0.
- Pop on dec_meta_valid & dec_meta_ready.

**Occupancy**
- Push and pop in the same cycle: occupancy unchanged; both operations take effect.
- Occupancy never exceeds MAX_OUTSTANDING and never underflows.

**Orphan response**
- dec_meta_valid=1 while occupancy=0 sets err_orphan<=1.
- err_orphan stays set until rst; the response is not accepted.

**Reset**
- rst clears rr_ptr=0, lock_vld=0, FIFO pointers, occupancy=0 and err_orphan=0.
- Outputs after reset: req_ready=0, rsp_valid=0, dec_req_valid=0, dec_meta_ready=0, outstanding=0, err_orphan=0.
- rst asserted mid-transfer drops all in-flight tags. The integrating level must reset the decoder in the same cycle.

## Timing
- Arbitration is combinational: a request presented in cycle N with dec_req_ready=1 is accepted in cycle N.
- Response path is combinational pass-through: zero added latency, zero bubbles.
- Sustained throughput: 1 request and 1 response per cycle.
- Credit release: a pop in cycle N frees a slot for eligibility in cycle N+1, because eligibility uses the registered occupancy.
- rr_ptr and lock state update at the clock edge that ends the cycle.

## Configuration
- META_ARB_QOS_EN defined: lane 0 wins whenever it is eligible and no grant is locked. Lanes 1..NUM_REQ-1 round-robin among themselves, and rr_ptr skips lane 0.
- META_ARB_QOS_EN undefined: pure round-robin over all lanes, as described above.

## Structure
- Package meta_arb_pkg holds:
  - constant META_ARB_MAX_REQ=8
  - typedef req_id_t, logic [$clog2(META_ARB_MAX_REQ)-1:0]
  - function rr_pick(valid vector, start pointer), returning the winner ID and a found flag
- Sub-module meta_arb_tag_fifo: synchronous FIFO with parameterised depth and data of type req_id_t.
  - Ports: push, pop, din, dout, empty, full, count.
  - Bypass is not allowed: pop on an empty FIFO is ignored.

## Test plan
Bench uses a decoder model with 1-cycle response latency returning 0xDEAD_0000+addr. Default parameters unless a scenario says otherwise.

1. **Reset**: hold rst 3 cycles with all lanes valid -> while rst is high, every output is 0. First release cycle grants lane 0.
2. **Fairness**: all 4 lanes valid continuously, lane i addr 0x10+i, dec_req_ready=1 -> grant order 0,1,2,3,0,1. Lane 2 receives rsp_rdata 0xDEAD_0012 on rsp_valid[2] only.
3. **Credit limit**: decoder withholds responses -> exactly 4 grants, then dec_req_valid=0 and outstanding=4. After one response pop, a new grant occurs in the next cycle.
4. **Grant lock**: lane 1 valid with addr 0x40, dec_req_ready=0 for 3 cycles, lane 0 raises valid in cycle 2 -> dec_req_addr stays 0x40 until accepted. Lane 0 is granted in the following cycle.
5. **Response backpressure and orphan**: head=lane 2 with rsp_ready[2]=0 for 4 cycles -> dec_meta_ready=0 and data is held. Then, with occupancy 0, inject dec_meta_valid -> err_orphan=1 and stays 1 until rst.
6. **QOS build (META_ARB_QOS_EN)**: lanes 0 and 3 continuously valid -> lane 0 wins every cycle. Lanes 1 and 3 only -> they alternate 1,3,1,3.

Source files
------------

// File: rtl/meta_arb_pkg.sv
// meta_arb_pkg: shared types and the round-robin pick helper for meta_req_arbiter.
package meta_arb_pkg;
    localparam int META_ARB_MAX_REQ = 8;

    typedef logic [$clog2(META_ARB_MAX_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } pick_t;

    // First set bit of valid at or after start, scanning upward modulo n.
    function automatic pick_t rr_pick(input logic [META_ARB_MAX_REQ-1:0] valid, input req_id_t start, input int n);
        pick_t p;
        int idx;
        p = '0;
        for (int k = META_ARB_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(start) + k;
                idx = (idx >= n) ? idx - n : idx;
                if (valid[idx]) p = '{found: 1'b1, id: req_id_t'(idx)};
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/meta_arb_tag_fifo.sv
// meta_arb_tag_fifo: in-order FIFO of granted requester IDs; push when full and pop when empty are ignored.
module meta_arb_tag_fifo
    import meta_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  req_id_t                  din_i,
    output req_id_t                  dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    req_id_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    always_comb begin
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == (AW+1)'(DEPTH));
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout_o  = mem_q[rd_q];
        count_o = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/meta_req_arbiter.sv
// meta_req_arbiter: round-robin sharing of one metadata decoder port among NUM_REQ lanes, responses routed in order.
// Define META_ARB_QOS_EN to give lane 0 strict priority while lanes 1..NUM_REQ-1 round-robin.
module meta_req_arbiter
    import meta_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic                            dec_req_valid_o,
    output logic [ADDR_WIDTH-1:0]           dec_req_addr_o,
    input  logic                            dec_req_ready_i,
    input  logic                            dec_meta_valid_i,
    input  logic [DATA_WIDTH-1:0]           dec_meta_rdata_i,
    output logic                            dec_meta_ready_o,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                            err_orphan_o
);
    logic [NUM_REQ-1:0] elig;
    pick_t              pick;
    req_id_t            win, head, rr_q, rr_d, lock_id_q, lock_id_d;
    logic               lock_vld_q, lock_vld_d, orphan_q, orphan_d;
    logic               full, empty, push, pop;

    // Eligibility uses the registered occupancy, so a pop frees a slot only on the next cycle.
    always_comb begin
        elig = req_valid_i & {NUM_REQ{~full & ~rst}};
`ifdef META_ARB_QOS_EN
        pick = rr_pick(META_ARB_MAX_REQ'(elig & ~NUM_REQ'(1)), rr_q, NUM_REQ);
        pick = elig[0] ? '{found: 1'b1, id: '0} : pick;
`else
        pick = rr_pick(META_ARB_MAX_REQ'(elig), rr_q, NUM_REQ);
`endif
        win             = lock_vld_q ? lock_id_q : pick.id;
        dec_req_valid_o = ~rst & (lock_vld_q | pick.found);
        dec_req_addr_o  = req_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        req_ready_o     = dec_req_valid_o ? NUM_REQ'(dec_req_ready_i) << win : '0;
        push            = dec_req_valid_o & dec_req_ready_i;
    end

    always_comb begin
        dec_meta_ready_o = ~rst & ~empty & |(rsp_ready_i & (NUM_REQ'(1) << head));
        rsp_valid_o      = (~rst & ~empty) ? NUM_REQ'(dec_meta_valid_i) << head : '0;
        rsp_rdata_o      = dec_meta_rdata_i;
        pop              = dec_meta_valid_i & dec_meta_ready_o;
        err_orphan_o     = orphan_q;
    end

    // A stalled grant is locked so valid and address stay stable until the decoder takes it.
    always_comb begin
        rr_d       = rr_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        orphan_d   = orphan_q | (dec_meta_valid_i & empty);
        if (push) begin
            lock_vld_d = 1'b0;
`ifdef META_ARB_QOS_EN
            rr_d = (win == '0) ? rr_q : (int'(win) == NUM_REQ - 1) ? req_id_t'(1) : win + 1'b1;
`else
            rr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
        end else if (dec_req_valid_o) begin
            lock_vld_d = 1'b1;
            lock_id_d  = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            orphan_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            orphan_q   <= orphan_d;
        end
    end

    meta_arb_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (win),
        .dout_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (outstanding_o)
    );
endmodule

// File: tb/tb_meta_req_arbiter.sv
// tb_meta_req_arbiter: directed self-checking bench with a 1-cycle-latency decoder model.
module tb_meta_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [DW-1:0]  rsp_rdata, dec_meta_rdata;
    logic [AW-1:0]  dec_req_addr;
    logic           dec_req_valid, dec_req_ready, dec_meta_valid, dec_meta_ready, err_orphan;
    logic [2:0]     outstanding;
    logic           rsp_en, orphan_inj, mdl_valid;
    logic [31:0]    mq [16];
    logic [3:0]     wp, rp;
    int             n_chk = 0;
    int             n_fail = 0;
    int             gorder [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    meta_req_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_addr_i       (req_addr),
        .req_ready_o      (req_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_ready_i      (rsp_ready),
        .dec_req_valid_o  (dec_req_valid),
        .dec_req_addr_o   (dec_req_addr),
        .dec_req_ready_i  (dec_req_ready),
        .dec_meta_valid_i (dec_meta_valid),
        .dec_meta_rdata_i (dec_meta_rdata),
        .dec_meta_ready_o (dec_meta_ready),
        .outstanding_o    (outstanding),
        .err_orphan_o     (err_orphan)
    );

    // Decoder model: answers each accepted request one cycle later with 0xDEAD_0000 + addr, in order.
    assign mdl_valid      = rsp_en && (wp != rp);
    assign dec_meta_valid = mdl_valid | orphan_inj;
    assign dec_meta_rdata = mq[rp];

    always @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (dec_req_valid && dec_req_ready) begin
                mq[wp] <= 32'hDEAD_0000 + dec_req_addr;
                wp     <= wp + 4'd1;
            end
            if (mdl_valid && dec_meta_ready) rp <= rp + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    task automatic pulse_rst;
        nxt;
        rst = 1'b1;
        req_valid = '0;
        nxt;
        rst = 1'b0;
    endtask

    initial begin
        req_valid     = '1;
        rsp_ready     = '1;
        dec_req_ready = 1'b1;
        rsp_en        = 1'b1;
        orphan_inj    = 1'b0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h10 + i;

        for (int c = 0; c < 3; c++) begin
            nxt;
            #1;
            chk("reset_outs", {req_ready, rsp_valid, dec_req_valid, dec_meta_ready, outstanding, err_orphan}, 64'd0);
        end
        nxt;
        rst = 1'b0;
        #1;
        chk("first_grant", req_ready, 64'b0001);

`ifndef META_ARB_QOS_EN
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                nxt;
                #1;
            end
            chk("rr_grant", req_ready, N'(1) << gorder[k]);
            chk("rr_addr", dec_req_addr, 32'h10 + gorder[k]);
            if (k == 3) begin
                chk("rsp_lane2_valid", rsp_valid, 64'b0100);
                chk("rsp_lane2_data", rsp_rdata, 32'hDEAD_0012);
            end
        end
`endif

        pulse_rst;
        rsp_en = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt;
            #1;
            chk("credit_grant", req_ready, N'(1) << k);
        end
        nxt;
        rsp_en = 1'b1;
        #1;
        chk("credit_stall", dec_req_valid, 64'd0);
        chk("credit_full", outstanding, 64'd4);
        chk("credit_rsp_valid", rsp_valid, 64'b0001);
        chk("credit_rsp_data", rsp_rdata, 32'hDEAD_0010);
        nxt;
        rsp_en = 1'b0;
        #1;
        chk("credit_release", req_ready, 64'b0001);
        chk("credit_occ", outstanding, 64'd3);
        nxt;
        req_valid = '0;
        rsp_en = 1'b1;
        repeat (4) nxt;
        #1;
        chk("drained", outstanding, 64'd0);
        req_valid = 4'b0100;
        #1;
        chk("pre_lock_grant", req_ready, 64'b0100);
        nxt;
        req_valid = '0;
        nxt;
        #1;
        chk("pre_lock_idle", outstanding, 64'd0);

        nxt;
        req_valid = 4'b0010;
        req_addr[AW +: AW] = 32'h40;
        dec_req_ready = 1'b0;
        #1;
        chk("lock_addr0", dec_req_addr, 32'h40);
        chk("lock_noready", req_ready, 64'd0);
        nxt;
        req_valid = 4'b0011;
        #1;
        chk("lock_addr1", dec_req_addr, 32'h40);
        nxt;
        #1;
        chk("lock_addr2", dec_req_addr, 32'h40);
        nxt;
        dec_req_ready = 1'b1;
        #1;
        chk("lock_accept_addr", dec_req_addr, 32'h40);
        chk("lock_accept", req_ready, 64'b0010);
        nxt;
        req_valid = 4'b0001;
        #1;
        chk("after_lock_grant", req_ready, 64'b0001);
        chk("after_lock_addr", dec_req_addr, 32'h10);
        chk("lock_rsp_valid", rsp_valid, 64'b0010);
        chk("lock_rsp_data", rsp_rdata, 32'hDEAD_0040);
        nxt;
        req_valid = '0;
        #1;
        chk("lane0_rsp_valid", rsp_valid, 64'b0001);
        chk("lane0_rsp_data", rsp_rdata, 32'hDEAD_0010);

        nxt;
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        #1;
        chk("bp_grant", req_ready, 64'b0100);
        nxt;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) nxt;
            #1;
            chk("bp_meta_ready", dec_meta_ready, 64'd0);
            chk("bp_rsp_valid", rsp_valid, 64'b0100);
            chk("bp_rsp_data", rsp_rdata, 32'hDEAD_0012);
        end
        nxt;
        rsp_ready = '1;
        #1;
        chk("bp_release", dec_meta_ready, 64'd1);
        nxt;
        #1;
        chk("bp_empty", outstanding, 64'd0);
        chk("orphan_clear", err_orphan, 64'd0);
        nxt;
        orphan_inj = 1'b1;
        #1;
        chk("orphan_not_accepted", dec_meta_ready, 64'd0);
        chk("orphan_no_rsp", rsp_valid, 64'd0);
        nxt;
        orphan_inj = 1'b0;
        #1;
        chk("orphan_set", err_orphan, 64'd1);
        repeat (3) nxt;
        #1;
        chk("orphan_sticky", err_orphan, 64'd1);
        pulse_rst;
        #1;
        chk("orphan_reset", err_orphan, 64'd0);
        chk("occ_reset", outstanding, 64'd0);

`ifdef META_ARB_QOS_EN
        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt;
            #1;
            chk("qos_lane0", req_ready, 64'b0001);
        end
        pulse_rst;
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt;
            #1;
            chk("qos_alt", req_ready, (k % 2 == 1) ? 64'b1000 : 64'b0010);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
